// File: rtl/msrv32_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | msrv32_pkg : shared encodings for the MSRV32 machine-mode trap controller    |
// | Revision   : 1.0                                                            |
// +----------------------------------------------------------------------------+
package msrv32_pkg;

  typedef enum logic [2:0] {
    ST_RESET       = 3'd0,
    ST_OPERATING   = 3'd1,
    ST_TRAP_TAKEN  = 3'd2,
    ST_TRAP_RETURN = 3'd3,
    ST_WFI         = 3'd4
  } mc_state_t;

  localparam logic [1:0] PC_BOOT = 2'b00;
  localparam logic [1:0] PC_NEXT = 2'b01;
  localparam logic [1:0] PC_EPC  = 2'b10;
  localparam logic [1:0] PC_TRAP = 2'b11;

  localparam int CODE_W = 4;

  localparam logic [CODE_W-1:0] EXC_INSTR_MISALIGNED = 4'd0;
  localparam logic [CODE_W-1:0] EXC_ILLEGAL_INSTR    = 4'd2;
  localparam logic [CODE_W-1:0] EXC_BREAKPOINT       = 4'd3;
  localparam logic [CODE_W-1:0] EXC_LOAD_MISALIGNED  = 4'd4;
  localparam logic [CODE_W-1:0] EXC_STORE_MISALIGNED = 4'd6;
  localparam logic [CODE_W-1:0] EXC_ECALL_M          = 4'd11;

  localparam logic [CODE_W-1:0] IRQ_M_SOFTWARE = 4'd3;
  localparam logic [CODE_W-1:0] IRQ_M_TIMER    = 4'd7;
  localparam logic [CODE_W-1:0] IRQ_M_EXTERNAL = 4'd11;

endpackage
`default_nettype wire

// File: rtl/msrv32_machine_control_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | msrv32_machine_control_if : trap-controller flags, CSR strobes and PC select |
// | Revision                  : 1.0                                            |
// +----------------------------------------------------------------------------+
interface msrv32_machine_control_if #(
  parameter int CAUSE_W = 4
);
  logic               illegal_instr_in;
  logic               misaligned_instr_in;
  logic               misaligned_load_in;
  logic               misaligned_store_in;
  logic               ecall_in;
  logic               ebreak_in;
  logic               mret_in;
  logic               wfi_in;
  logic               mie_in;
  logic               meie_in;
  logic               mtie_in;
  logic               msie_in;
  logic               meip_in;
  logic               mtip_in;
  logic               msip_in;

  logic [1:0]         pc_src_out;
  logic               flush_out;
  logic               trap_taken_out;
  logic               set_epc_out;
  logic               set_cause_out;
  logic [CAUSE_W-1:0] cause_out;
  logic               i_or_e_out;
  logic               mie_clear_out;
  logic               mie_set_out;
  logic               instret_inc_out;
  logic               stall_out;

  modport master (
    output illegal_instr_in, misaligned_instr_in, misaligned_load_in,
           misaligned_store_in, ecall_in, ebreak_in, mret_in, wfi_in,
           mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in,
    input  pc_src_out, flush_out, trap_taken_out, set_epc_out, set_cause_out,
           cause_out, i_or_e_out, mie_clear_out, mie_set_out,
           instret_inc_out, stall_out
  );

  modport slave (
    input  illegal_instr_in, misaligned_instr_in, misaligned_load_in,
           misaligned_store_in, ecall_in, ebreak_in, mret_in, wfi_in,
           mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in,
    output pc_src_out, flush_out, trap_taken_out, set_epc_out, set_cause_out,
           cause_out, i_or_e_out, mie_clear_out, mie_set_out,
           instret_inc_out, stall_out
  );
endinterface
`default_nettype wire

// File: rtl/msrv32_trap_priority_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | msrv32_trap_priority_encoder : picks the winning trap source and its code    |
// | Revision                     : 1.0                                         |
// +----------------------------------------------------------------------------+
module msrv32_trap_priority_encoder
  import msrv32_pkg::*;
(
  input  logic              illegal_instr_in,
  input  logic              misaligned_instr_in,
  input  logic              misaligned_load_in,
  input  logic              misaligned_store_in,
  input  logic              ecall_in,
  input  logic              ebreak_in,
  input  logic              mie_in,
  input  logic              meie_in,
  input  logic              mtie_in,
  input  logic              msie_in,
  input  logic              meip_in,
  input  logic              mtip_in,
  input  logic              msip_in,
  output logic              valid_out,
  output logic              i_or_e_out,
  output logic [CODE_W-1:0] cause_out,
  output logic              irq_wake_out,
  output logic [CODE_W-1:0] irq_cause_out
);

  logic              exc_valid;
  logic [CODE_W-1:0] exc_cause;

  always_comb begin
    exc_valid = 1'b1;
    exc_cause = EXC_ILLEGAL_INSTR;
    if (illegal_instr_in)         exc_cause = EXC_ILLEGAL_INSTR;
    else if (misaligned_instr_in) exc_cause = EXC_INSTR_MISALIGNED;
    else if (ecall_in)            exc_cause = EXC_ECALL_M;
    else if (ebreak_in)           exc_cause = EXC_BREAKPOINT;
    else if (misaligned_load_in)  exc_cause = EXC_LOAD_MISALIGNED;
    else if (misaligned_store_in) exc_cause = EXC_STORE_MISALIGNED;
    else                          exc_valid = 1'b0;
  end

  // Wake ignores mstatus.MIE so a WFI can resume even with interrupts masked.
  always_comb begin
    irq_wake_out  = 1'b1;
    irq_cause_out = IRQ_M_EXTERNAL;
    if (meie_in && meip_in)      irq_cause_out = IRQ_M_EXTERNAL;
    else if (msie_in && msip_in) irq_cause_out = IRQ_M_SOFTWARE;
    else if (mtie_in && mtip_in) irq_cause_out = IRQ_M_TIMER;
    else                         irq_wake_out  = 1'b0;
  end

  assign valid_out  = exc_valid | (mie_in & irq_wake_out);
  assign i_or_e_out = ~exc_valid;
  assign cause_out  = exc_valid ? exc_cause : irq_cause_out;

endmodule
`default_nettype wire

// File: rtl/msrv32_machine_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | msrv32_machine_control : machine-mode trap entry / mret sequencer            |
// | Optional WFI sleep state enabled by defining MSRV32_WFI_EN. Revision : 1.0   |
// +----------------------------------------------------------------------------+
module msrv32_machine_control
  import msrv32_pkg::*;
#(
  parameter int CAUSE_W = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  msrv32_machine_control_if.slave  bus
);

  mc_state_t          state_q, state_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic               i_or_e_q, i_or_e_d;

  logic               trap_valid;
  logic               trap_i_or_e;
  logic [CODE_W-1:0]  trap_cause;
  logic               irq_wake;
  logic [CODE_W-1:0]  irq_cause;

  logic [1:0]         pc_src;
  logic               flush;
  logic               trap_taken;
  logic               mie_clear;
  logic               mie_set;
  logic               instret_inc;
  logic               stall;

  msrv32_trap_priority_encoder u_prio (
    .illegal_instr_in    (bus.illegal_instr_in),
    .misaligned_instr_in (bus.misaligned_instr_in),
    .misaligned_load_in  (bus.misaligned_load_in),
    .misaligned_store_in (bus.misaligned_store_in),
    .ecall_in            (bus.ecall_in),
    .ebreak_in           (bus.ebreak_in),
    .mie_in              (bus.mie_in),
    .meie_in             (bus.meie_in),
    .mtie_in             (bus.mtie_in),
    .msie_in             (bus.msie_in),
    .meip_in             (bus.meip_in),
    .mtip_in             (bus.mtip_in),
    .msip_in             (bus.msip_in),
    .valid_out           (trap_valid),
    .i_or_e_out          (trap_i_or_e),
    .cause_out           (trap_cause),
    .irq_wake_out        (irq_wake),
    .irq_cause_out       (irq_cause)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= ST_RESET;
      cause_q  <= '0;
      i_or_e_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      i_or_e_q <= i_or_e_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    i_or_e_d    = i_or_e_q;
    pc_src      = PC_BOOT;
    flush       = 1'b0;
    trap_taken  = 1'b0;
    mie_clear   = 1'b0;
    mie_set     = 1'b0;
    instret_inc = 1'b0;
    stall       = 1'b0;

    case (state_q)
      ST_RESET: begin
        pc_src  = PC_BOOT;
        flush   = 1'b1;
        state_d = ST_OPERATING;
      end

      ST_OPERATING: begin
        pc_src      = PC_NEXT;
        instret_inc = ~(trap_valid | bus.mret_in);
        // Exceptions outrank mret so a faulting mret still traps.
        if (trap_valid) begin
          state_d  = ST_TRAP_TAKEN;
          cause_d  = CAUSE_W'(trap_cause);
          i_or_e_d = trap_i_or_e;
        end else if (bus.mret_in) begin
          state_d = ST_TRAP_RETURN;
        end
`ifdef MSRV32_WFI_EN
        else if (bus.wfi_in) begin
          state_d = ST_WFI;
        end
`endif
      end

      ST_TRAP_TAKEN: begin
        pc_src     = PC_TRAP;
        flush      = 1'b1;
        trap_taken = 1'b1;
        mie_clear  = 1'b1;
        state_d    = ST_OPERATING;
      end

      ST_TRAP_RETURN: begin
        pc_src  = PC_EPC;
        flush   = 1'b1;
        mie_set = 1'b1;
        state_d = ST_OPERATING;
      end

`ifdef MSRV32_WFI_EN
      ST_WFI: begin
        pc_src = PC_NEXT;
        stall  = 1'b1;
        if (irq_wake) begin
          if (bus.mie_in) begin
            state_d  = ST_TRAP_TAKEN;
            cause_d  = CAUSE_W'(irq_cause);
            i_or_e_d = 1'b1;
          end else begin
            state_d = ST_OPERATING;
          end
        end
      end
`endif

      default: begin
        flush   = 1'b1;
        state_d = ST_RESET;
      end
    endcase
  end

`ifndef MSRV32_WFI_EN
  logic unused_wfi;
  assign unused_wfi = bus.wfi_in;
`endif

  assign bus.pc_src_out      = pc_src;
  assign bus.flush_out       = flush;
  assign bus.trap_taken_out  = trap_taken;
  assign bus.set_epc_out     = trap_taken;
  assign bus.set_cause_out   = trap_taken;
  assign bus.cause_out       = cause_q;
  assign bus.i_or_e_out      = i_or_e_q;
  assign bus.mie_clear_out   = mie_clear;
  assign bus.mie_set_out     = mie_set;
  assign bus.instret_inc_out = instret_inc;
  assign bus.stall_out       = stall;

endmodule
`default_nettype wire

// File: tb/tb_msrv32_machine_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_msrv32_machine_control : randomized + directed bench for the trap FSM     |
// | Revision                  : 1.0                                            |
// +----------------------------------------------------------------------------+
module tb_msrv32_machine_control;

  localparam int CW = 4;
  localparam int VW = 11 + CW;
`ifdef MSRV32_WFI_EN
  localparam bit WFI_EN = 1'b1;
`else
  localparam bit WFI_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  msrv32_machine_control_if #(.CAUSE_W(CW)) bus ();
  msrv32_machine_control #(.CAUSE_W(CW)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  // Reference model: which kind of cycle the controller is in, plus the latched cause.
  typedef enum int {M_RESET, M_RUN, M_TRAP, M_RETURN, M_SLEEP} mmode_t;
  mmode_t m_mode  = M_RESET;
  int     m_cause = 0;
  bit     m_ioe   = 1'b0;
  int     exc_code [6] = '{2, 0, 11, 3, 4, 6};

  function automatic int exc_now();
    bit f [6];
    f[0] = bus.illegal_instr_in;   f[1] = bus.misaligned_instr_in;
    f[2] = bus.ecall_in;           f[3] = bus.ebreak_in;
    f[4] = bus.misaligned_load_in; f[5] = bus.misaligned_store_in;
    for (int i = 0; i < 6; i++) if (f[i]) return exc_code[i];
    return -1;
  endfunction

  function automatic int irq_now();
    if (bus.meie_in && bus.meip_in) return 11;
    if (bus.msie_in && bus.msip_in) return 3;
    if (bus.mtie_in && bus.mtip_in) return 7;
    return -1;
  endfunction

  task automatic model_step();
    int  e;
    int  q;
    e = exc_now();
    q = irq_now();
    if (!rst_n) begin
      m_mode = M_RESET; m_cause = 0; m_ioe = 1'b0;
      return;
    end
    case (m_mode)
      M_RUN: begin
        if (e >= 0) begin
          m_mode = M_TRAP; m_cause = e; m_ioe = 1'b0;
        end else if (bus.mie_in && q >= 0) begin
          m_mode = M_TRAP; m_cause = q; m_ioe = 1'b1;
        end else if (bus.mret_in) m_mode = M_RETURN;
        else if (WFI_EN && bus.wfi_in) m_mode = M_SLEEP;
      end
      M_SLEEP: begin
        if (q >= 0) begin
          if (bus.mie_in) begin
            m_mode = M_TRAP; m_cause = q; m_ioe = 1'b1;
          end else m_mode = M_RUN;
        end
      end
      default: m_mode = M_RUN;
    endcase
  endtask

  function automatic logic [VW-1:0] expect_vec();
    logic [1:0] pc;
    bit tt, ms, fl, st, ret;
    tt = (m_mode == M_TRAP);
    ms = (m_mode == M_RETURN);
    st = (m_mode == M_SLEEP);
    fl = (m_mode == M_RESET) || tt || ms;
    case (m_mode)
      M_RESET:  pc = 2'b00;
      M_TRAP:   pc = 2'b11;
      M_RETURN: pc = 2'b10;
      default:  pc = 2'b01;
    endcase
    ret = (m_mode == M_RUN) && (exc_now() < 0) && !(bus.mie_in && irq_now() >= 0)
          && !bus.mret_in;
    return {pc, fl, tt, tt, tt, tt, ms, ret, st, CW'(m_cause), m_ioe};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {bus.pc_src_out, bus.flush_out, bus.trap_taken_out, bus.set_epc_out,
            bus.set_cause_out, bus.mie_clear_out, bus.mie_set_out,
            bus.instret_inc_out, bus.stall_out, bus.cause_out, bus.i_or_e_out};
  endfunction

  task automatic clear_inputs();
    bus.illegal_instr_in = 0; bus.misaligned_instr_in = 0;
    bus.misaligned_load_in = 0; bus.misaligned_store_in = 0;
    bus.ecall_in = 0; bus.ebreak_in = 0; bus.mret_in = 0; bus.wfi_in = 0;
    bus.mie_in = 0; bus.meie_in = 0; bus.mtie_in = 0; bus.msie_in = 0;
    bus.meip_in = 0; bus.mtip_in = 0; bus.msip_in = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    m_mode = M_RESET; m_cause = 0; m_ioe = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      tests_run++;
      if (obs_vec() !== expect_vec()) begin
        tests_failed++;
        $display("FAIL reset_hold[%0d]: got %h want %h", i, obs_vec(), expect_vec());
      end
      tick();
    end
    @(negedge clk); rst_n = 1'b1; #1;
    tests_run++;
    if (bus.pc_src_out !== 2'b00 || bus.flush_out !== 1'b1 || obs_vec() !== expect_vec()) begin
      tests_failed++;
      $display("FAIL reset_release: got %h want %h", obs_vec(), expect_vec());
    end
    tick();
    @(negedge clk); #1;
    tests_run++;
    if (bus.pc_src_out !== 2'b01 || bus.instret_inc_out !== 1'b1 || obs_vec() !== expect_vec()) begin
      tests_failed++;
      $display("FAIL reset_to_operating: got %h want %h", obs_vec(), expect_vec());
    end
  endtask

  task automatic test_exception_priority();
    @(negedge clk); clear_inputs();
    bus.illegal_instr_in = 1; bus.ecall_in = 1; #1;
    tests_run++;
    if (obs_vec() !== expect_vec()) begin
      tests_failed++;
      $display("FAIL exc_accept: got %h want %h", obs_vec(), expect_vec());
    end
    tick();
    @(negedge clk); clear_inputs(); #1;
    tests_run++;
    if (bus.cause_out !== 4'd2 || bus.i_or_e_out !== 1'b0 || bus.pc_src_out !== 2'b11 ||
        bus.set_epc_out !== 1'b1 || bus.set_cause_out !== 1'b1 || bus.mie_clear_out !== 1'b1 ||
        obs_vec() !== expect_vec()) begin
      tests_failed++;
      $display("FAIL exc_trap_taken: got %h want %h", obs_vec(), expect_vec());
    end
    tick();
    @(negedge clk); #1;
    tests_run++;
    if (bus.pc_src_out !== 2'b01 || obs_vec() !== expect_vec()) begin
      tests_failed++;
      $display("FAIL exc_back_to_run: got %h want %h", obs_vec(), expect_vec());
    end
  endtask

  task automatic test_interrupt();
    @(negedge clk); clear_inputs();
    bus.mie_in = 1; bus.meie_in = 1; bus.meip_in = 1; bus.mtie_in = 1; bus.mtip_in = 1; #1;
    tick();
    @(negedge clk); clear_inputs(); #1;
    tests_run++;
    if (bus.cause_out !== 4'd11 || bus.i_or_e_out !== 1'b1 || obs_vec() !== expect_vec()) begin
      tests_failed++;
      $display("FAIL irq_ext_taken: got %h want %h", obs_vec(), expect_vec());
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); clear_inputs();
      bus.meie_in = 1; bus.meip_in = 1; bus.mtie_in = 1; bus.mtip_in = 1; #1;
      tests_run++;
      if (bus.instret_inc_out !== 1'b1 || obs_vec() !== expect_vec()) begin
        tests_failed++;
        $display("FAIL irq_masked[%0d]: got %h want %h", i, obs_vec(), expect_vec());
      end
      tick();
    end
  endtask

  task automatic test_mret();
    @(negedge clk); clear_inputs(); bus.mret_in = 1; bus.misaligned_load_in = 1; #1;
    tick();
    @(negedge clk); clear_inputs(); #1;
    tests_run++;
    if (bus.cause_out !== 4'd4 || bus.trap_taken_out !== 1'b1 || obs_vec() !== expect_vec()) begin
      tests_failed++;
      $display("FAIL mret_vs_exc: got %h want %h", obs_vec(), expect_vec());
    end
    tick();
    @(negedge clk); clear_inputs(); bus.mret_in = 1; #1;
    tests_run++;
    if (bus.instret_inc_out !== 1'b0 || obs_vec() !== expect_vec()) begin
      tests_failed++;
      $display("FAIL mret_accept: got %h want %h", obs_vec(), expect_vec());
    end
    tick();
    @(negedge clk); clear_inputs(); #1;
    tests_run++;
    if (bus.pc_src_out !== 2'b10 || bus.mie_set_out !== 1'b1 || bus.flush_out !== 1'b1 ||
        obs_vec() !== expect_vec()) begin
      tests_failed++;
      $display("FAIL mret_return: got %h want %h", obs_vec(), expect_vec());
    end
    tick();
  endtask

  task automatic test_reset_mid_trap();
    @(negedge clk); clear_inputs(); bus.ebreak_in = 1; #1;
    tick();
    @(negedge clk); clear_inputs(); #1;
    tests_run++;
    if (bus.trap_taken_out !== 1'b1 || bus.cause_out !== 4'd3 || obs_vec() !== expect_vec()) begin
      tests_failed++;
      $display("FAIL midtrap_pre: got %h want %h", obs_vec(), expect_vec());
    end
    rst_n = 1'b0; #1;
    m_mode = M_RESET; m_cause = 0; m_ioe = 1'b0;
    tests_run++;
    if (bus.pc_src_out !== 2'b00 || bus.cause_out !== 4'd0 || bus.flush_out !== 1'b1 ||
        obs_vec() !== expect_vec()) begin
      tests_failed++;
      $display("FAIL midtrap_async_reset: got %h want %h", obs_vec(), expect_vec());
    end
    tick();
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    @(negedge clk); clear_inputs(); bus.mie_in = 1; bus.mtie_in = 1; bus.mtip_in = 1; #1;
    tick();
    @(negedge clk); bus.mie_in = 0; #1;
    tick();
    @(negedge clk); bus.mret_in = 1; #1;
    tick();
    @(negedge clk); bus.mret_in = 0; bus.mie_in = 1; #1;
    tests_run++;
    if (bus.mie_set_out !== 1'b1 || obs_vec() !== expect_vec()) begin
      tests_failed++;
      $display("FAIL b2b_return: got %h want %h", obs_vec(), expect_vec());
    end
    tick();
    @(negedge clk); #1;
    tests_run++;
    if (bus.instret_inc_out !== 1'b0 || obs_vec() !== expect_vec()) begin
      tests_failed++;
      $display("FAIL b2b_first_run: got %h want %h", obs_vec(), expect_vec());
    end
    tick();
    @(negedge clk); clear_inputs(); #1;
    tests_run++;
    if (bus.trap_taken_out !== 1'b1 || bus.cause_out !== 4'd7 || bus.i_or_e_out !== 1'b1 ||
        obs_vec() !== expect_vec()) begin
      tests_failed++;
      $display("FAIL b2b_retrap: got %h want %h", obs_vec(), expect_vec());
    end
    tick();
  endtask

`ifdef MSRV32_WFI_EN
  task automatic test_wfi();
    @(negedge clk); clear_inputs(); bus.wfi_in = 1; #1;
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); clear_inputs(); #1;
      tests_run++;
      if (bus.stall_out !== 1'b1 || obs_vec() !== expect_vec()) begin
        tests_failed++;
        $display("FAIL wfi_stall[%0d]: got %h want %h", i, obs_vec(), expect_vec());
      end
      tick();
    end
    @(negedge clk); bus.msie_in = 1; bus.msip_in = 1; bus.mie_in = 1; #1;
    tick();
    @(negedge clk); clear_inputs(); #1;
    tests_run++;
    if (bus.cause_out !== 4'd3 || bus.i_or_e_out !== 1'b1 || obs_vec() !== expect_vec()) begin
      tests_failed++;
      $display("FAIL wfi_wake_trap: got %h want %h", obs_vec(), expect_vec());
    end
    tick();
    @(negedge clk); bus.wfi_in = 1; #1;
    tick();
    @(negedge clk); clear_inputs(); bus.msie_in = 1; bus.msip_in = 1; #1;
    tick();
    @(negedge clk); #1;
    tests_run++;
    if (bus.stall_out !== 1'b0 || bus.pc_src_out !== 2'b01 || obs_vec() !== expect_vec()) begin
      tests_failed++;
      $display("FAIL wfi_wake_masked: got %h want %h", obs_vec(), expect_vec());
    end
    tick();
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); clear_inputs();
      bus.illegal_instr_in    = ($urandom_range(0, 23) == 0);
      bus.misaligned_instr_in = ($urandom_range(0, 23) == 0);
      bus.misaligned_load_in  = ($urandom_range(0, 23) == 0);
      bus.misaligned_store_in = ($urandom_range(0, 23) == 0);
      bus.ecall_in            = ($urandom_range(0, 23) == 0);
      bus.ebreak_in           = ($urandom_range(0, 23) == 0);
      bus.mret_in             = ($urandom_range(0, 7) == 0);
      bus.wfi_in              = ($urandom_range(0, 7) == 0);
      bus.mie_in              = 1'($urandom_range(0, 1));
      bus.meie_in             = 1'($urandom_range(0, 1));
      bus.mtie_in             = 1'($urandom_range(0, 1));
      bus.msie_in             = 1'($urandom_range(0, 1));
      bus.meip_in             = ($urandom_range(0, 5) == 0);
      bus.mtip_in             = ($urandom_range(0, 5) == 0);
      bus.msip_in             = ($urandom_range(0, 5) == 0);
      #1;
      tests_run++;
      if (obs_vec() !== expect_vec()) begin
        tests_failed++;
        $display("FAIL random[%0d]: got %h want %h", i, obs_vec(), expect_vec());
      end
      tick();
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_exception_priority();
    test_interrupt();
    test_mret();
    test_reset_mid_trap();
    test_back_to_back();
`ifdef MSRV32_WFI_EN
    test_wfi();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/msrv32_machine_control.md
Name: msrv32_machine_control

Overview:
- Machine-mode trap controller of the MSRV32 core.
- Watches exception flags from decode/LSU and pending interrupts from the CSR file. Sequences trap entry (TRAP_TAKEN) and mret return (TRAP_RETURN).
- Drives pc_src_out to the PC mux and the CSR update strobes.
- Sole producer of flush_out, consumed as flush_in by msrv32_wr_en_generator to suppress integer/CSR writeback.

Parameters:
CAUSE_W, 4, width of cause_out (mcause exception code field).

Ports:
clk_in  input  1  core clock
rst_n_in  input  1  asynchronous active-low reset
illegal_instr_in  input  1  decoder: illegal opcode
misaligned_instr_in  input  1  fetch target not 4-byte aligned
misaligned_load_in  input  1  LSU load address misaligned
misaligned_store_in  input  1  LSU store address misaligned
ecall_in  input  1  decoded ECALL
ebreak_in  input  1  decoded EBREAK
mret_in  input  1  decoded MRET
wfi_in  input  1  decoded WFI (used only with MSRV32_WFI_EN)
mie_in  input  1  mstatus.MIE
meie_in, mtie_in, msie_in  input  1 each  mie.MEIE/MTIE/MSIE
meip_in, mtip_in, msip_in  input  1 each  external/timer/software pending
pc_src_out  output  2  00 boot, 01 next PC, 10 mepc, 11 trap vector
flush_out  output  1  kill instruction in writeback stage
trap_taken_out  output  1  trap entry this cycle
set_epc_out  output  1  write mepc
set_cause_out  output  1  write mcause
cause_out  output  CAUSE_W  mcause code
i_or_e_out  output  1  1 = interrupt, 0 = exception
mie_clear_out  output  1  MIE->MPIE, MIE<=0
mie_set_out  output  1  MPIE->MIE
instret_inc_out  output  1  increment minstret
stall_out  output  1  hold fetch (WFI)

Behaviour:
- Reset: clk_in and rst_n_in are the sole clock and reset. rst_n_in low asynchronously forces state RESET, cause_out=0 and i_or_e_out=0, regardless of current state (including mid-trap).
- States: RESET, OPERATING, TRAP_TAKEN, TRAP_RETURN, WFI (WFI only with the macro). Encoding is 3 bits.
- Outputs are Moore-decoded from state. cause_out and i_or_e_out are registered on the transition into TRAP_TAKEN and hold until the next trap.
- RESET: pc_src=00, flush=1, all strobes 0. Goes unconditionally to OPERATING on the next edge.
- OPERATING: pc_src=01, flush=0. instret_inc=1 unless a trap or mret is being accepted this cycle.
  - exc = any exception input.
  - irq = mie_in & ((meie&meip)|(mtie&mtip)|(msie&msip)).
  - exc|irq -> TRAP_TAKEN. Else mret -> TRAP_RETURN. Else stay.
  - Exception with simultaneous mret: exception wins.
- Exception priority and codes:
  - illegal 2
  - instr misaligned 0
  - ecall 11
  - ebreak 3
  - load misaligned 4
  - store misaligned 6
  - Any exception beats any interrupt.
- Interrupt priority and codes: external 11, software 3, timer 7. i_or_e_out=1 for interrupts.
- TRAP_TAKEN (exactly 1 cycle):
  - pc_src=11, flush=1, trap_taken=1, set_epc=1, set_cause=1, mie_clear=1.
  - Next state OPERATING.
  - Inputs are ignored; pending sources are re-evaluated in OPERATING.
- TRAP_RETURN (1 cycle): pc_src=10, flush=1, mie_set=1, then OPERATING.
- instret_inc=0 in every state except OPERATING.
- Back-to-back: an interrupt still pending after return is taken on the first OPERATING cycle, since mie_in is now 1.

Optional Feature:
MSRV32_WFI_EN:
- Defined:
  - OPERATING with wfi_in and no exc/irq/mret -> WFI.
  - WFI: stall_out=1, pc_src=01, flush=0, instret_inc=0.
  - Exit when any enabled source is pending ((meie&meip)|(mtie&mtip)|(msie&msip)), independent of mie_in. If mie_in=1 -> TRAP_TAKEN with the interrupt cause; else -> OPERATING.
- Undefined: WFI state is absent, wfi_in is ignored (WFI acts as NOP), stall_out tied 0.

Decomposition:
- Package msrv32_pkg holds: state encodings, pc_src encodings (PC_BOOT/PC_NEXT/PC_EPC/PC_TRAP), exception and interrupt cause constants.
- Sub-module msrv32_trap_priority_encoder: combinational; turns exception/interrupt flags into {valid, i_or_e, cause}.

Test Plan:
- Assert rst_n_in low for 2 cycles, then release -> RESET with pc_src=00, flush=1; next edge OPERATING with pc_src=01, instret_inc=1.
- Pulse illegal_instr_in=1 with ecall_in=1 -> one TRAP_TAKEN cycle: cause_out=2, i_or_e=0, pc_src=11, flush=1, set_epc=set_cause=mie_clear=1; then OPERATING.
- Set mie=1, meie=meip=1, mtie=mtip=1 -> TRAP_TAKEN with cause=11, i_or_e=1. Repeat with mie=0 -> no trap, instret_inc stays 1.
- Pulse mret_in with misaligned_load_in -> TRAP_TAKEN with cause 4. Pulse mret_in alone -> TRAP_RETURN: pc_src=10, mie_set=1, flush=1.
- Drop rst_n_in in the TRAP_TAKEN cycle -> immediate RESET, cause_out=0, flush=1.
- (MSRV32_WFI_EN) wfi_in=1 -> stall_out=1 held 5 cycles. Then set msip=msie=1 with mie=1 -> TRAP_TAKEN with cause 3. With mie=0 -> OPERATING, stall_out=0.
